sprite_animator: RTL and testbench

SPRITE_ANIMATOR -- requirements
Module: sprite_animator

---
 rtl/sprite_pkg.sv | 28 ++
 rtl/sprite_anim_fsm.sv | 130 +++++++++++++
 rtl/sprite_animator.sv | 123 ++++++++++++
 tb/tb_sprite_animator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared encodings for the sprite animator: animation modes, FSM states, transparent color.
// Latency: none (types and constants only).
// Backpressure: none.
package sprite_pkg;

  // Animation mode encodings driven on the mode port
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_LOOP     = 2'b00;
  localparam mode_t MODE_PINGPONG = 2'b01;
  localparam mode_t MODE_ONESHOT  = 2'b10;
  localparam mode_t MODE_HOLD     = 2'b11;

  // Frame sequencer states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FWD  = 2'd1;
  localparam state_t ST_REV  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Pixel color that is never drawn
  localparam int TRANSPARENT = 0;

  // Modes that run only while the moving input is held
  function automatic logic is_continuous(input mode_t m);
    return (m == MODE_LOOP) || (m == MODE_PINGPONG);
  endfunction

endpackage

// File: rtl/sprite_anim_fsm.sv
// Animation frame sequencer: tick divider plus IDLE/FWD/REV/DONE state machine.
// Latency: frame_idx_o and anim_done_o are registered, one cycle after the deciding inputs.
// Backpressure: none; hold mode freezes the counter, the state and the frame index.
module sprite_anim_fsm
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES  = 3,
  parameter int FRAME_TICKS = 8_000_000,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  mode_t         mode_i,
  input  logic          moving_i,
  input  logic          start_i,
  output logic [FW-1:0] frame_idx_o,
  output logic          anim_done_o
);

  localparam logic [FW-1:0] LAST   = FW'(NUM_FRAMES - 1);
  localparam logic [FW-1:0] REST   = FW'(1);
  localparam logic [TW-1:0] RELOAD = TW'(FRAME_TICKS - 1);

  state_t        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          done_q, done_d;

  logic          hold, stop, run, strobe;
  logic [FW-1:0] frame_inc;

  // Run qualifiers: hold freezes everything, dropping moving aborts a continuous animation
  always_comb begin
    hold      = (mode_i == MODE_HOLD);
    stop      = is_continuous(mode_i) && !moving_i &&
                ((state_q == ST_FWD) || (state_q == ST_REV));
    run       = !hold && !stop && ((state_q == ST_FWD) || (state_q == ST_REV));
    strobe    = run && (tick_q == '0);
    frame_inc = frame_q + FW'(1);
  end

  // Next state, next frame and tick divider
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    tick_d  = tick_q;
    if (!hold) begin
      case (state_q)
        ST_IDLE: begin
          frame_d = REST;
          // start is honoured here before any strobe can count, so it always restarts at frame 0
          if ((moving_i && is_continuous(mode_i)) ||
              (start_i && (mode_i == MODE_ONESHOT))) begin
            state_d = ST_FWD;
            frame_d = '0;
          end
        end
        ST_FWD: begin
          if (strobe) begin
            if (frame_q == LAST) begin
              // Only reachable in loop, or after a mode change mid-animation
              case (mode_i)
                MODE_PINGPONG: begin
                  state_d = ST_REV;
                  frame_d = LAST - FW'(1);
                end
                MODE_ONESHOT: state_d = ST_DONE;
                default:      frame_d = '0;
              endcase
            end else begin
              frame_d = frame_inc;
              if (frame_inc == LAST) begin
                if (mode_i == MODE_PINGPONG) state_d = ST_REV;
                if (mode_i == MODE_ONESHOT)  state_d = ST_DONE;
              end
            end
          end
        end
        ST_REV: begin
          if (strobe) begin
            if (frame_q == '0) begin
              state_d = ST_FWD;
              frame_d = FW'(1);
            end else begin
              frame_d = frame_q - FW'(1);
              if (frame_q == FW'(1)) state_d = ST_FWD;
            end
          end
        end
        ST_DONE: begin
          frame_d = LAST;
          if (!start_i) begin
            state_d = ST_IDLE;
            frame_d = REST;
          end
        end
        default: begin
          state_d = ST_IDLE;
          frame_d = REST;
        end
      endcase
      if (stop) begin
        state_d = ST_IDLE;
        frame_d = REST;
      end
      tick_d = (!run || strobe) ? RELOAD : (tick_q - TW'(1));
    end
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // State registers with synchronous reset taking priority over all inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      frame_q <= REST;
      tick_q  <= RELOAD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign frame_idx_o = frame_q;
  assign anim_done_o = done_q;

endmodule

// File: rtl/sprite_animator.sv
// Animated sprite renderer: frame sequencing, vsync-latched display state, hit test and sprite-ROM pixel fetch.
// Latency: mem_addr 1 cycle and pixel_out/pixel_valid 2 cycles after pixel_row/pixel_col; mem_data sampled 1 cycle after mem_addr.
// Backpressure: none, streams one pixel per cycle. Optional SPRITE_MIRROR_EN enables horizontal flip via mirror_x.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int SPRITE_W    = 34,
  parameter int SPRITE_H    = 34,
  parameter int NUM_FRAMES  = 3,
  parameter int NUM_ROWS    = 8,
  parameter int FRAME_TICKS = 8_000_000,
  parameter int ADDR_W      = 16,
  parameter int COLOR_W     = 12,
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        pixel_row,
  input  logic [11:0]        pixel_col,
  input  logic [11:0]        pos_x,
  input  logic [11:0]        pos_y,
  input  logic [RW-1:0]      row_sel,
  input  logic [1:0]         mode,
  input  logic               moving,
  input  logic               start,
  input  logic               vsync,
  input  logic               mirror_x,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_data,
  output logic [COLOR_W-1:0] pixel_out,
  output logic               pixel_valid,
  output logic [FW-1:0]      frame_idx,
  output logic               anim_done
);

  localparam logic signed [12:0] SW13     = 13'(SPRITE_W);
  localparam logic signed [12:0] SH13     = 13'(SPRITE_H);
  localparam logic [COLOR_W-1:0] TRANSP_C = COLOR_W'(TRANSPARENT);

  // Frame sequencer
  sprite_anim_fsm #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .mode_i      (mode),
    .moving_i    (moving),
    .start_i     (start),
    .frame_idx_o (frame_idx),
    .anim_done_o (anim_done)
  );

  // Display copies only move at the frame boundary so a scanout never mixes two frames
  logic [RW-1:0] row_disp_q;
  logic [FW-1:0] frame_disp_q;

  // Latch the displayed row and frame on vsync
  always_ff @(posedge clk) begin
    if (reset) begin
      row_disp_q   <= '0;
      frame_disp_q <= FW'(1);
    end else if (vsync) begin
      row_disp_q   <= row_sel;
      frame_disp_q <= frame_idx;
    end
  end

  logic signed [12:0] lx, ly, lx_addr;
  logic               hit_d, hit_q;
  logic [ADDR_W-1:0]  mem_addr_d, mem_addr_q;
  logic [COLOR_W-1:0] pix_d, pix_q;
  logic               vld_d, vld_q;

  // Sprite-local coordinates; 13-bit signed so pixels left of/above the sprite go negative
  always_comb begin
    lx    = $signed({1'b0, pixel_col}) - $signed({1'b0, pos_x});
    ly    = $signed({1'b0, pixel_row}) - $signed({1'b0, pos_y});
    hit_d = !lx[12] && (lx < SW13) && !ly[12] && (ly < SH13);
  end

`ifdef SPRITE_MIRROR_EN
  // Horizontal flip only changes which column is fetched, not the hit window
  assign lx_addr = mirror_x ? (SW13 - 13'sd1 - lx) : lx;
`else
  logic unused_mirror;
  assign lx_addr       = lx;
  assign unused_mirror = mirror_x;
`endif

  // Sheet layout: rows of orientation, each row holds NUM_FRAMES sprites side by side
  always_comb begin
    mem_addr_d = ADDR_W'((int'(row_disp_q) * SPRITE_H + int'(ly)) * (NUM_FRAMES * SPRITE_W)
                         + int'(frame_disp_q) * SPRITE_W + int'(lx_addr));
  end

  // Second stage: color 0 is transparent and never reported as a valid pixel
  always_comb begin
    vld_d = hit_q && (mem_data != TRANSP_C);
    pix_d = vld_d ? mem_data : TRANSP_C;
  end

  // Pixel pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q <= '0;
      hit_q      <= 1'b0;
      pix_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      hit_q      <= hit_d;
      pix_q      <= pix_d;
      vld_q      <= vld_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign pixel_out   = pix_q;
  assign pixel_valid = vld_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator with FRAME_TICKS=4: pixel-path table plus FSM sequences.
// Latency: checks mem_addr one edge and pixel_out two edges after the pixel inputs.
// Backpressure: none; every wait is a fixed number of clock edges.
module tb_sprite_animator;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pixel_row, pixel_col, pos_x, pos_y;
  logic [2:0]  row_sel;
  logic [1:0]  mode;
  logic        moving, start, vsync, mirror_x;
  logic [15:0] mem_addr;
  logic [11:0] mem_data;
  logic [11:0] pixel_out;
  logic        pixel_valid;
  logic [1:0]  frame_idx;
  logic        anim_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sprite_animator #(.FRAME_TICKS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_row   (pixel_row),
    .pixel_col   (pixel_col),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .row_sel     (row_sel),
    .mode        (mode),
    .moving      (moving),
    .start       (start),
    .vsync       (vsync),
    .mirror_x    (mirror_x),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .frame_idx   (frame_idx),
    .anim_done   (anim_done)
  );

  typedef struct {
    logic [11:0] pc, pr, px, py;
    logic        mir;
    logic [11:0] md;
    logic [15:0] addr;
    logic        vld;
    logic [11:0] out;
  } vec_t;

`ifdef SPRITE_MIRROR_EN
  localparam logic [15:0] MIR_ADDR = 16'd10471;
`else
  localparam logic [15:0] MIR_ADDR = 16'd10438;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    vec_t vt[10];
    int   lseq[4];
    int   pseq[6];

    // row 3, frame 1 latched: addr = 10438 + 102*ly + lx
    vt[0] = '{12'd11,   12'd22,   12'd10,   12'd20,   1'b0, 12'h000, 16'd10643, 1'b0, 12'h000};
    vt[1] = '{12'd10,   12'd20,   12'd10,   12'd20,   1'b0, 12'hABC, 16'd10438, 1'b1, 12'hABC};
    vt[2] = '{12'd43,   12'd53,   12'd10,   12'd20,   1'b0, 12'h123, 16'd13837, 1'b1, 12'h123};
    vt[3] = '{12'd44,   12'd20,   12'd10,   12'd20,   1'b0, 12'hFFF, 16'd10472, 1'b0, 12'h000};
    vt[4] = '{12'd9,    12'd20,   12'd10,   12'd20,   1'b0, 12'hFFF, 16'd10437, 1'b0, 12'h000};
    vt[5] = '{12'd10,   12'd54,   12'd10,   12'd20,   1'b0, 12'h005, 16'd13906, 1'b0, 12'h000};
    vt[6] = '{12'd10,   12'd19,   12'd10,   12'd20,   1'b0, 12'h005, 16'd10336, 1'b0, 12'h000};
    vt[7] = '{12'd4095, 12'd4033, 12'd4090, 12'd4000, 1'b0, 12'h007, 16'd13809, 1'b1, 12'h007};
    vt[8] = '{12'd5,    12'd5,    12'd100,  12'd100,  1'b0, 12'h001, 16'd653,   1'b0, 12'h000};
    vt[9] = '{12'd10,   12'd20,   12'd10,   12'd20,   1'b1, 12'h009, MIR_ADDR,  1'b1, 12'h009};
    lseq = '{0, 1, 2, 0};
    pseq = '{0, 1, 2, 1, 0, 1};

    reset = 1'b1; pixel_row = '0; pixel_col = '0; pos_x = '0; pos_y = '0;
    row_sel = '0; mode = 2'b00; moving = 1'b0; start = 1'b0; vsync = 1'b0;
    mirror_x = 1'b0; mem_data = '0;
    step(); step();
    chk("rst_frame", frame_idx, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pix", pixel_out, 0);
    chk("rst_vld", pixel_valid, 0);
    chk("rst_done", anim_done, 0);
    reset = 1'b0;

    // Display copies after reset are row 0, frame 1
    pixel_col = 12'd10; pixel_row = 12'd20; pos_x = 12'd10; pos_y = 12'd20;
    step();
    chk("rst_disp_addr", mem_addr, 34);

    row_sel = 3'd3; vsync = 1'b1;
    step();
    vsync = 1'b0;

    for (int i = 0; i < 10; i++) begin
      pixel_col = vt[i].pc; pixel_row = vt[i].pr;
      pos_x = vt[i].px; pos_y = vt[i].py; mirror_x = vt[i].mir;
      step();
      chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].addr);
      mem_data = vt[i].md;
      step();
      chk($sformatf("vec%0d_vld", i), pixel_valid, vt[i].vld);
      chk($sformatf("vec%0d_pix", i), pixel_out, vt[i].out);
    end
    mirror_x = 1'b0;

    // Row change without vsync must not reach the address
    pixel_col = 12'd11; pixel_row = 12'd22; pos_x = 12'd10; pos_y = 12'd20;
    row_sel = 3'd5;
    step();
    chk("tear_hold", mem_addr, 10643);
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    chk("tear_vsync", mem_addr, 17579);

    // Loop mode
    mode = 2'b00; moving = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("loop_k%0d", k), frame_idx, lseq[k/4]);
    end
    moving = 1'b0;
    step();
    chk("loop_stop", frame_idx, 1);

    // Ping-pong mode
    mode = 2'b01; moving = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      chk($sformatf("pp_k%0d", k), frame_idx, pseq[k/4]);
    end
    moving = 1'b0;
    step();
    chk("pp_stop", frame_idx, 1);

    // Restart: full four-cycle period for frame 0
    moving = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("restart_k%0d", k), frame_idx, (k < 4) ? 0 : 1);
    end
    step();

    // Hold freezes frame and tick counter
    mode = 2'b11;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("hold_k%0d", k), frame_idx, 1);
    end
    mode = 2'b01;
    step();
    chk("hold_res0", frame_idx, 1);
    step();
    chk("hold_res1", frame_idx, 1);
    step();
    chk("hold_res2", frame_idx, 2);
    moving = 1'b0;
    step();
    chk("hold_stop", frame_idx, 1);

    // One-shot
    mode = 2'b10; start = 1'b1;
    step();
    chk("os_start", frame_idx, 0);
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("os_k%0d", k), frame_idx, (k < 4) ? 0 : 1);
      chk($sformatf("os_done_k%0d", k), anim_done, 0);
    end
    start = 1'b1;
    step();
    chk("os_last", frame_idx, 2);
    chk("os_done_pulse", anim_done, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("os_held_k%0d", k), frame_idx, 2);
      chk($sformatf("os_done_low_k%0d", k), anim_done, 0);
    end
    start = 1'b0;
    step();
    chk("os_idle", frame_idx, 1);
    chk("os_idle_done", anim_done, 0);

    // Reset mid-animation beats vsync, start and moving
    mode = 2'b00; moving = 1'b1; mem_data = 12'h0AA;
    pixel_col = 12'd11; pixel_row = 12'd22; pos_x = 12'd10; pos_y = 12'd20;
    for (int k = 0; k < 6; k++) step();
    chk("pre_rst_frame", frame_idx, 1);
    reset = 1'b1; start = 1'b1; vsync = 1'b1; row_sel = 3'd6;
    step();
    chk("mid_rst_frame", frame_idx, 1);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_vld", pixel_valid, 0);
    chk("mid_rst_pix", pixel_out, 0);
    chk("mid_rst_done", anim_done, 0);
    reset = 1'b0; start = 1'b0; vsync = 1'b0;
    step();
    chk("post_rst_frame", frame_idx, 0);
    chk("post_rst_addr", mem_addr, 239);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
